// File: rtl/mems_pkg.sv
// Shared definitions for the MEMS scan engine: SPI frame layout, scan mode
// encoding and the frame shifter state type.
package mems_pkg;

    localparam int         FRAME_W          = 24;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;

    typedef enum logic {
        MODE_SAW = 1'b0,
        MODE_TRI = 1'b1
    } scan_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/mems_spi_frame.sv
// Single-frame SPI shifter for the MEMS DAC (CPOL=0, CPHA=1, MSB first).
// A start pulse in IDLE (or in the last GAP cycle) launches one frame;
// o_done pulses in the last GAP cycle. SCK half-period H = 2^(CLK_DIV-1).
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        launch a frame (sampled in IDLE and in the last GAP cycle)
//   i_frame        24-bit frame word, read during LOAD
//   o_sck, o_mosi  SPI clock / data
//   o_cs           active-low chip select (forced high while i_rst is high)
//   o_done         one-cycle pulse in the final GAP cycle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | CS high, waiting for i_start
// ST_LOAD  | one cycle, shift register captures i_frame
// ST_LEAD  | CS low, SCK low, H cycles before the first bit
// ST_SHIFT | 24 bits, SCK low H then high H; MOSI updates on SCK rise
// ST_TRAIL | SCK low, CS still low, H cycles
// ST_GAP   | CS high, 2H cycles; done pulses in the last one
module mems_spi_frame
    import mems_pkg::*;
#(
    parameter int CLK_DIV = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_sck,
    output logic               o_mosi,
    output logic               o_cs,
    output logic               o_done
);

    localparam int              H        = 1 << (CLK_DIV - 1);
    localparam int              TW       = CLK_DIV + 1;
    localparam logic [TW-1:0]   T_HALF   = TW'(H - 1);
    localparam logic [TW-1:0]   T_GAP    = TW'(2 * H - 1);
    localparam logic [4:0]      LAST_BIT = 5'(FRAME_W - 1);

    spi_state_e         r_state, w_state_nxt;
    logic [TW-1:0]      r_tmr, w_tmr_nxt;
    logic [4:0]         r_bit, w_bit_nxt;
    logic               r_phase_hi, w_phase_hi_nxt;
    logic [FRAME_W-1:0] r_shift, w_shift_nxt;
    logic               r_sck, w_sck_nxt;
    logic               r_mosi, w_mosi_nxt;
    logic               r_cs_n, w_cs_n_nxt;
    logic               w_tmr_tc;

    assign w_tmr_tc = (r_tmr == '0);

    // Output registers are driven from next-state values so that SCK/CS
    // edges line up with state entry and come straight from flops.
    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_nxt      = w_tmr_tc ? '0 : r_tmr - TW'(1);
        w_bit_nxt      = r_bit;
        w_phase_hi_nxt = r_phase_hi;
        w_shift_nxt    = r_shift;
        w_sck_nxt      = r_sck;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;
        o_done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_shift_nxt = i_frame;
                w_tmr_nxt   = T_HALF;
                w_cs_n_nxt  = 1'b0;
                w_state_nxt = ST_LEAD;
            end
            ST_LEAD: begin
                if (w_tmr_tc) begin
                    w_state_nxt    = ST_SHIFT;
                    w_tmr_nxt      = T_HALF;
                    w_bit_nxt      = LAST_BIT;
                    w_phase_hi_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_tmr_tc) begin
                    w_tmr_nxt = T_HALF;
                    if (!r_phase_hi) begin
                        w_phase_hi_nxt = 1'b1;
                        w_sck_nxt      = 1'b1;
                        w_mosi_nxt     = r_shift[FRAME_W-1];
                        w_shift_nxt    = {r_shift[FRAME_W-2:0], 1'b0};
                    end else begin
                        w_phase_hi_nxt = 1'b0;
                        w_sck_nxt      = 1'b0;
                        if (r_bit == '0) begin
                            w_state_nxt = ST_TRAIL;
                        end else begin
                            w_bit_nxt = r_bit - 5'd1;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (w_tmr_tc) begin
                    w_state_nxt = ST_GAP;
                    w_tmr_nxt   = T_GAP;
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                end
            end
            ST_GAP: begin
                if (w_tmr_tc) begin
                    o_done      = 1'b1;
                    w_state_nxt = i_start ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_bit      <= '0;
            r_phase_hi <= 1'b0;
            r_shift    <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_bit      <= w_bit_nxt;
            r_phase_hi <= w_phase_hi_nxt;
            r_shift    <= w_shift_nxt;
            r_sck      <= w_sck_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
        end
    end

    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;
    // Chip select releases combinationally on reset so the DAC sees the
    // frame aborted without waiting for a clock edge.
    assign o_cs   = r_cs_n | i_rst;

endmodule

// File: rtl/mems_scan_engine.sv
// Multi-axis MEMS scan engine: per-channel sawtooth/triangle phase
// accumulators, update-tick generation, channel sequencing onto a shared
// SPI DAC link, and the free-running MEMS filter clock.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_enable        1 = ticks are generated
//   i_mode          0 = sawtooth, 1 = triangle (all channels)
//   i_step          per-channel phase increment, channel 0 in the LSBs
//   i_tick_div      update period in clk cycles (0 behaves as 1)
//   o_sck, o_mosi   SPI clock / data
//   o_cs            active-low DAC chip select
//   o_fclk          MEMS filter clock, period 2*FCLK_DIV
//   o_busy          tick in progress
//   o_frame_done    pulse when all channels of a tick are sent
//   o_overrun       pulse when a tick is dropped because busy
module mems_scan_engine
    import mems_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 9,
    parameter int FCLK_DIV = 5000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_mode,
    input  logic [CHANNELS*DATA_W-1:0] i_step,
    input  logic [15:0]                i_tick_div,
    output logic                       o_sck,
    output logic                       o_mosi,
    output logic                       o_cs,
    output logic                       o_fclk,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic                       o_overrun
);

    localparam int                CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int                FW     = (FCLK_DIV > 1) ? $clog2(FCLK_DIV) : 1;
    localparam logic [FW-1:0]     F_LOAD = FW'(FCLK_DIV - 1);
    localparam logic [DATA_W-1:0] PH_MAX = '1;

    logic [15:0]        r_tick_cnt;
    logic [15:0]        w_tdiv;
    logic               w_tick;

    logic [DATA_W-1:0]  r_phase  [CHANNELS];
    logic [DATA_W-1:0]  r_sample [CHANNELS];
    logic [CHANNELS-1:0] r_dir;
    logic [DATA_W-1:0]  w_step      [CHANNELS];
    logic [DATA_W:0]    w_sum       [CHANNELS];
    logic [DATA_W-1:0]  w_phase_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_dir_nxt;

    logic               r_busy;
    logic               r_first;
    logic [CW-1:0]      r_chan;
    logic [CW-1:0]      w_next_chan;
    logic               w_last;
    logic               w_start;
    logic               w_done;
    logic [15:0]        w_word;
    logic [FRAME_W-1:0] w_frame;
    logic               r_frame_done;
    logic               r_overrun;

    logic [FW-1:0]      r_fclk_cnt;
    logic               r_fclk;

    assign w_tdiv = (i_tick_div == 16'd0) ? 16'd1 : i_tick_div;
    // >= rather than == so lowering tick_div mid-count still wraps promptly.
    assign w_tick = i_enable && (r_tick_cnt >= (w_tdiv - 16'd1));

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // Phase update; r_dir = 1 means the triangle is descending.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_step[c]      = i_step[c*DATA_W +: DATA_W];
            w_sum[c]       = {1'b0, r_phase[c]} + {1'b0, w_step[c]};
            w_phase_nxt[c] = r_phase[c];
            w_dir_nxt[c]   = r_dir[c];
            if (scan_mode_e'(i_mode) == MODE_SAW) begin
                w_phase_nxt[c] = w_sum[c][DATA_W-1:0];
            end else if (!r_dir[c]) begin
                if (w_sum[c] >= {1'b0, PH_MAX}) begin
                    w_phase_nxt[c] = PH_MAX;
                    w_dir_nxt[c]   = 1'b1;
                end else begin
                    w_phase_nxt[c] = w_sum[c][DATA_W-1:0];
                end
            end else begin
                if (r_phase[c] <= w_step[c]) begin
                    w_phase_nxt[c] = '0;
                    w_dir_nxt[c]   = 1'b0;
                end else begin
                    w_phase_nxt[c] = r_phase[c] - w_step[c];
                end
            end
        end
    end

    assign w_last      = (r_chan == CW'(CHANNELS - 1));
    assign w_next_chan = r_first ? '0 : r_chan + CW'(1);
    // The first channel launches from IDLE one cycle after tick acceptance;
    // later channels chain straight out of the previous GAP.
    assign w_start     = r_first | (w_done & ~w_last);
    assign w_word      = 16'(r_sample[r_chan]) << (16 - DATA_W);
    assign w_frame     = {CMD_WRITE_UPDATE, 4'(r_chan), w_word};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy       <= 1'b0;
            r_first      <= 1'b0;
            r_chan       <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_dir        <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_phase[c]  <= '0;
                r_sample[c] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            if (w_tick) begin
                if (r_busy) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_busy  <= 1'b1;
                    r_first <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_sample[c] <= r_phase[c];
                    end
                end
            end
            if (w_start) begin
                r_first <= 1'b0;
                r_chan  <= w_next_chan;
            end
            if (w_done && w_last) begin
                r_busy       <= 1'b0;
                r_frame_done <= 1'b1;
                r_dir        <= w_dir_nxt;
                for (int c = 0; c < CHANNELS; c++) begin
                    r_phase[c] <= w_phase_nxt[c];
                end
            end
        end
    end

    mems_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_frame (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_frame (w_frame),
        .o_sck   (o_sck),
        .o_mosi  (o_mosi),
        .o_cs    (o_cs),
        .o_done  (w_done)
    );

    // Loading FCLK_DIV-1 in reset puts the first rising edge exactly
    // FCLK_DIV cycles after reset release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fclk_cnt <= F_LOAD;
            r_fclk     <= 1'b0;
        end else if (r_fclk_cnt == '0) begin
            r_fclk_cnt <= F_LOAD;
            r_fclk     <= ~r_fclk;
        end else begin
            r_fclk_cnt <= r_fclk_cnt - FW'(1);
        end
    end

    assign o_fclk       = r_fclk;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_mems_scan_engine.sv
module tb_mems_scan_engine;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int CD = 2;
    localparam int FD = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             mode = 1'b0;
    logic [CH*DW-1:0] step = '0;
    logic [15:0]      tick_div = 16'd400;
    logic             sck, mosi, cs, fclk, busy, frame_done, overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mems_scan_engine #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .CLK_DIV  (CD),
        .FCLK_DIV (FD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_mode       (mode),
        .i_step       (step),
        .i_tick_div   (tick_div),
        .o_sck        (sck),
        .o_mosi       (mosi),
        .o_cs         (cs),
        .o_fclk       (fclk),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_overrun    (overrun)
    );

    // SPI receiver model: DAC samples MOSI on SCK falling edges.
    logic [23:0] mon_frm [64];
    int          mon_nfrm = 0;
    int          mon_nbad = 0;
    int          mon_nbusy = 0;
    int          mon_ndone = 0;
    int          mon_novr = 0;
    int          mon_bits = 0;
    logic [23:0] mon_sh = '0;
    logic        mon_psck = 1'b0;
    logic        mon_pcs = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            mon_bits <= 0;
            mon_psck <= 1'b0;
            mon_pcs  <= 1'b1;
        end else begin
            mon_psck <= sck;
            mon_pcs  <= cs;
            if (mon_psck && !sck && !cs) begin
                mon_sh   <= {mon_sh[22:0], mosi};
                mon_bits <= mon_bits + 1;
            end
            if (cs && !mon_pcs) begin
                if (mon_bits == 24 && mon_nfrm < 64) begin
                    mon_frm[mon_nfrm] <= mon_sh;
                    mon_nfrm <= mon_nfrm + 1;
                end else begin
                    mon_nbad <= mon_nbad + 1;
                end
                mon_bits <= 0;
            end
            if (busy)       mon_nbusy <= mon_nbusy + 1;
            if (frame_done) mon_ndone <= mon_ndone + 1;
            if (overrun)    mon_novr  <= mon_novr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            cyc();
            if (frame_done) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        mode;
        logic [15:0] st0;
        logic [15:0] st1;
        logic [23:0] exp0;
        logic [23:0] exp1;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        int viol, first, tog, badgap, lat, base, b0, ovr0, done0, rises;
        logic pf, ps;
        logic [23:0] exp_ovr [6];

        // inputs applied after tick i's frames; expected = tick i samples
        vecs[0]  = '{1'b0, 16'h0010, 16'h0100, 24'h300000, 24'h310000};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0100, 24'h300010, 24'h310100};
        vecs[2]  = '{1'b0, 16'h8000, 16'h0000, 24'h300020, 24'h310200};
        vecs[3]  = '{1'b0, 16'h7FE0, 16'hFFFF, 24'h308020, 24'h310200};
        vecs[4]  = '{1'b0, 16'h8000, 16'h0000, 24'h300000, 24'h3101FF};
        vecs[5]  = '{1'b0, 16'h8000, 16'h0000, 24'h308000, 24'h3101FF};
        vecs[6]  = '{1'b1, 16'h6000, 16'h0000, 24'h300000, 24'h3101FF};
        vecs[7]  = '{1'b1, 16'h6000, 16'h0000, 24'h306000, 24'h3101FF};
        vecs[8]  = '{1'b1, 16'h6000, 16'h0000, 24'h30C000, 24'h3101FF};
        vecs[9]  = '{1'b1, 16'h6000, 16'h0000, 24'h30FFFF, 24'h3101FF};
        vecs[10] = '{1'b1, 16'h6000, 16'h0000, 24'h309FFF, 24'h3101FF};
        vecs[11] = '{1'b1, 16'h6000, 16'h0000, 24'h303FFF, 24'h3101FF};
        vecs[12] = '{1'b1, 16'h6000, 16'h0000, 24'h300000, 24'h3101FF};
        vecs[13] = '{1'b1, 16'h6000, 16'h0000, 24'h306000, 24'h3101FF};
        vecs[14] = '{1'b1, 16'h6000, 16'hFE00, 24'h30C000, 24'h3101FF};
        vecs[15] = '{1'b0, 16'h0001, 16'h0001, 24'h30FFFF, 24'h31FFFF};
        vecs[16] = '{1'b0, 16'h0001, 16'h0001, 24'h300000, 24'h310000};

        // reset values
        rst = 1'b1;
        repeat (3) cyc();
        check("reset_outputs", {25'd0, sck, mosi, cs, fclk, busy, frame_done, overrun}, 32'b0010000);

        // idle with enable low: link quiet, fclk free-running
        rst = 1'b0;
        viol = 0; first = 0; tog = 0; badgap = 0; pf = 1'b0;
        for (int c = 1; c <= 500; c++) begin
            cyc();
            if (cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0) viol++;
            if (fclk !== pf) begin
                if (first == 0) first = c;
                if (c % FD != 0) badgap++;
                tog++;
                pf = fclk;
            end
        end
        check("idle_link_quiet", viol, 0);
        check("idle_no_frames", mon_nfrm + mon_nbad, 0);
        check("fclk_first_rise", first, FD);
        check("fclk_toggles", tog, 500 / FD);
        check("fclk_period", badgap, 0);

        // table: saw / wrap / triangle / mode switch, tick_div = 400
        base = mon_nfrm;
        ovr0 = mon_novr;
        done0 = mon_ndone;
        mode = vecs[0].mode;
        step = {vecs[0].st1, vecs[0].st0};
        tick_div = 16'd400;
        b0 = mon_nbusy;
        enable = 1'b1;
        lat = 0;
        while (!busy && lat < 1000) begin
            cyc();
            lat++;
        end
        check("first_tick_latency", lat, 400);
        for (int i = 0; i < NV; i++) begin
            wait_done($sformatf("vec%0d_done", i));
            check($sformatf("vec%0d_busy_cycles", i), mon_nbusy - b0, 211);
            check($sformatf("vec%0d_frame0", i), {8'd0, mon_frm[base + 2*i]}, {8'd0, vecs[i].exp0});
            check($sformatf("vec%0d_frame1", i), {8'd0, mon_frm[base + 2*i + 1]}, {8'd0, vecs[i].exp1});
            b0 = mon_nbusy;
            if (i + 1 < NV) begin
                mode = vecs[i+1].mode;
                step = {vecs[i+1].st1, vecs[i+1].st0};
            end
        end
        check("table_no_overrun", mon_novr - ovr0, 0);
        check("table_done_pulses", mon_ndone - done0, NV);
        check("table_bad_frames", mon_nbad, 0);

        // overrun: tick_div 100 < 211 busy cycles
        enable = 1'b0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        mode = 1'b0;
        step = {16'h0002, 16'h0001};
        tick_div = 16'd100;
        base = mon_nfrm;
        ovr0 = mon_novr;
        done0 = mon_ndone;
        enable = 1'b1;
        for (int j = 0; j < 3; j++) wait_done($sformatf("ovr_tick%0d", j));
        check("overrun_pulses", mon_novr - ovr0, 6);
        check("overrun_done_pulses", mon_ndone - done0, 3);
        exp_ovr[0] = 24'h300000; exp_ovr[1] = 24'h310000;
        exp_ovr[2] = 24'h300001; exp_ovr[3] = 24'h310002;
        exp_ovr[4] = 24'h300002; exp_ovr[5] = 24'h310004;
        for (int j = 0; j < 6; j++)
            check($sformatf("ovr_frame%0d", j), {8'd0, mon_frm[base + j]}, {8'd0, exp_ovr[j]});

        // reset mid-SHIFT, then restart from sample 0
        enable = 1'b0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        enable = 1'b1;
        rises = 0;
        ps = 1'b0;
        for (int k = 0; k < 2000 && rises < 3; k++) begin
            cyc();
            if (sck && !ps) rises++;
            ps = sck;
        end
        check("midshift_third_rise", rises, 3);
        check("midshift_mosi_bit2", {31'd0, mosi}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_cs_immediate", {31'd0, cs}, 32'd1);
        cyc();
        check("rst_outputs", {28'd0, sck, mosi, cs, busy}, 32'b0010);
        rst = 1'b0;
        base = mon_nfrm;
        wait_done("restart");
        check("restart_frame0", {8'd0, mon_frm[base]}, {8'd0, 24'h300000});
        check("restart_frame1", {8'd0, mon_frm[base + 1]}, {8'd0, 24'h310000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
